// File: rtl/i2c_target_buffered.sv
// i2c_target_buffered
//   I2C target (slave) with a multi-byte receive buffer and an optional
//   read-back path. Write payload bytes land in rx_data (first byte in the
//   MSBs). Read transfers shift out tx_data MSB byte first. Bytes read past
//   TX_BYTES come back as 8'hFF.
//
//   Optional feature macro: I2C_TARGET_READ_EN
//     defined   : RD/RD_ACK path present, RW=1 to our address is ACKed.
//     undefined : RW=1 is NACKed, tx_data unused, tx_done tied low.
//
// Ports
//   clk       system clock, scl/sda sampled on its rising edge
//   reset_n   asynchronous active-low reset
//   scl       I2C clock input
//   sda       I2C data, driven only to 0 or Z
//   rx_data   received payload, 8*RX_BYTES bits
//   rx_count  payload bytes ACKed in current/last write
//   rx_valid  1-clk pulse, STOP after a complete write
//   rx_error  1-clk pulse, STOP/rSTART after a short write
//   tx_data   read payload, captured at the address ACK
//   tx_done   1-clk pulse, master NACKed a read byte
//   busy      high from matching address ACK until STOP
module i2c_target_buffered #(
  parameter logic [6:0] ADDRESS     = 7'h6A,
  parameter int         RX_BYTES    = 33,
  parameter int         TX_BYTES    = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  scl,
  inout  wire                   sda,
  output logic [8*RX_BYTES-1:0] rx_data,
  output logic [9:0]            rx_count,
  output logic                  rx_valid,
  output logic                  rx_error,
  input  logic [8*TX_BYTES-1:0] tx_data,
  output logic                  tx_done,
  output logic                  busy
);

  localparam int TXW = 8 * TX_BYTES;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR, WR_ACK, IGNORE
`ifdef I2C_TARGET_READ_EN
    , RD, RD_ACK
`endif
  } stateT;

  stateT                 state_q;
  logic [SYNC_STAGES-1:0] sclSync_q, sdaSync_q;
  logic [2:0]            bitCnt_q;
  logic                  byteDone_q;
  logic [7:0]            shift_q;
  logic                  sdaLow_q;
  logic [8*RX_BYTES-1:0] rxData_q;
  logic [9:0]            rxCount_q;
  logic                  rxValid_q, rxError_q, txDone_q, busy_q;
  logic                  wrActive_q;
`ifdef I2C_TARGET_READ_EN
  logic                  rw_q;
  logic [TXW-1:0]        txBuf_q;
`endif

  // Index 0 is the newest sample; edges compare the two oldest stages.
  logic sclNow, sclOld, sdaNow, sdaOld;
  logic sclRise, sclFall, startDet, stopDet;
  logic rwAllowed;

  assign sclNow   = sclSync_q[SYNC_STAGES-2];
  assign sclOld   = sclSync_q[SYNC_STAGES-1];
  assign sdaNow   = sdaSync_q[SYNC_STAGES-2];
  assign sdaOld   = sdaSync_q[SYNC_STAGES-1];
  assign sclRise  = sclNow & ~sclOld;
  assign sclFall  = ~sclNow & sclOld;
  assign startDet = sclNow & sclOld & sdaOld & ~sdaNow;
  assign stopDet  = sclNow & sclOld & ~sdaOld & sdaNow;

`ifdef I2C_TARGET_READ_EN
  assign rwAllowed = 1'b1;
  assign tx_done   = txDone_q;
`else
  logic unusedTxData;
  assign unusedTxData = ^tx_data;
  assign rwAllowed    = ~shift_q[0];
  assign tx_done      = 1'b0;
`endif

  // Open-drain output: only ever pull low or release.
  assign sda      = sdaLow_q ? 1'b0 : 1'bz;
  assign rx_data  = rxData_q;
  assign rx_count = rxCount_q;
  assign rx_valid = rxValid_q;
  assign rx_error = rxError_q;
  assign busy     = busy_q;

  // Synchronisers reset to 1 so an idle (pulled-up) bus shows no edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclSync_q <= '1;
      sdaSync_q <= '1;
    end else begin
      sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl};
      sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda};
    end
  end

  // Protocol FSM. STOP and START override every state; otherwise bits are
  // sampled on scl rise and sda is only changed on scl fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bitCnt_q   <= 3'd7;
      byteDone_q <= 1'b0;
      shift_q    <= '0;
      sdaLow_q   <= 1'b0;
      rxData_q   <= '0;
      rxCount_q  <= '0;
      rxValid_q  <= 1'b0;
      rxError_q  <= 1'b0;
      txDone_q   <= 1'b0;
      busy_q     <= 1'b0;
      wrActive_q <= 1'b0;
`ifdef I2C_TARGET_READ_EN
      rw_q       <= 1'b0;
      txBuf_q    <= '0;
`endif
    end else begin
      rxValid_q <= 1'b0;
      rxError_q <= 1'b0;
      txDone_q  <= 1'b0;
      if (stopDet) begin
        state_q    <= IDLE;
        sdaLow_q   <= 1'b0;
        busy_q     <= 1'b0;
        wrActive_q <= 1'b0;
        if (wrActive_q) begin
          if (rxCount_q == 10'(RX_BYTES)) rxValid_q <= 1'b1;
          else if (rxCount_q != '0)       rxError_q <= 1'b1;
        end
      end else if (startDet) begin
        state_q    <= ADDR;
        bitCnt_q   <= 3'd7;
        byteDone_q <= 1'b0;
        sdaLow_q   <= 1'b0;
        wrActive_q <= 1'b0;
        if (wrActive_q && rxCount_q != '0 && rxCount_q != 10'(RX_BYTES))
          rxError_q <= 1'b1;
      end else begin
        case (state_q)
          ADDR: begin
            if (sclRise) begin
              shift_q <= {shift_q[6:0], sdaNow};
              if (bitCnt_q == 3'd0) byteDone_q <= 1'b1;
              else                  bitCnt_q   <= bitCnt_q - 3'd1;
            end else if (sclFall && byteDone_q) begin
              byteDone_q <= 1'b0;
              if (shift_q[7:1] == ADDRESS && rwAllowed) begin
                sdaLow_q <= 1'b1;
                busy_q   <= 1'b1;
                state_q  <= ADDR_ACK;
`ifdef I2C_TARGET_READ_EN
                rw_q     <= shift_q[0];
`endif
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (sclFall) begin
              bitCnt_q <= 3'd7;
`ifdef I2C_TARGET_READ_EN
              if (rw_q) begin
                // First read bit goes out on the same fall that ends the ACK.
                txBuf_q  <= tx_data;
                sdaLow_q <= ~tx_data[TXW-1];
                state_q  <= RD;
              end else begin
                sdaLow_q   <= 1'b0;
                rxCount_q  <= '0;
                wrActive_q <= 1'b1;
                state_q    <= WR;
              end
`else
              sdaLow_q   <= 1'b0;
              rxCount_q  <= '0;
              wrActive_q <= 1'b1;
              state_q    <= WR;
`endif
            end
          end
          WR: begin
            if (sclRise) begin
              shift_q <= {shift_q[6:0], sdaNow};
              if (bitCnt_q == 3'd0) byteDone_q <= 1'b1;
              else                  bitCnt_q   <= bitCnt_q - 3'd1;
            end else if (sclFall && byteDone_q) begin
              byteDone_q <= 1'b0;
              if (rxCount_q < 10'(RX_BYTES)) begin
                for (int i = 0; i < RX_BYTES; i++)
                  if (rxCount_q == 10'(i)) rxData_q[8*(RX_BYTES-1-i) +: 8] <= shift_q;
                rxCount_q <= rxCount_q + 10'd1;
                sdaLow_q  <= 1'b1;
                state_q   <= WR_ACK;
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          WR_ACK: begin
            if (sclFall) begin
              sdaLow_q <= 1'b0;
              bitCnt_q <= 3'd7;
              state_q  <= WR;
            end
          end
`ifdef I2C_TARGET_READ_EN
          RD: begin
            // Shifting in 1s makes bytes beyond TX_BYTES read as 8'hFF.
            if (sclRise) begin
              if (bitCnt_q == 3'd0) byteDone_q <= 1'b1;
              else                  bitCnt_q   <= bitCnt_q - 3'd1;
            end else if (sclFall) begin
              txBuf_q <= {txBuf_q[TXW-2:0], 1'b1};
              if (byteDone_q) begin
                byteDone_q <= 1'b0;
                sdaLow_q   <= 1'b0;
                state_q    <= RD_ACK;
              end else begin
                sdaLow_q <= ~txBuf_q[TXW-2];
              end
            end
          end
          RD_ACK: begin
            if (sclRise) begin
              if (!sdaNow) begin
                byteDone_q <= 1'b1;
              end else begin
                txDone_q <= 1'b1;
                state_q  <= IGNORE;
              end
            end else if (sclFall && byteDone_q) begin
              byteDone_q <= 1'b0;
              bitCnt_q   <= 3'd7;
              sdaLow_q   <= ~txBuf_q[TXW-1];
              state_q    <= RD;
            end
          end
`endif
          default: sdaLow_q <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_buffered.sv
// tb_i2c_target_buffered
//   Directed bench for i2c_target_buffered. A bit-banged I2C master drives
//   scl and an open-drain sda; each scenario task compares DUT outputs with
//   hand-computed expectations. Pulse outputs are counted by a monitor so
//   both occurrence and 1-clk width are checked.
module tb_i2c_target_buffered;

  localparam int Q = 60;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         scl = 1'b1;
  logic         mLow = 1'b0;
  wire          sda;
  logic [263:0] rx_data;
  logic [9:0]   rx_count;
  logic         rx_valid, rx_error, tx_done, busy;
  logic [127:0] txData = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  logic [263:0] expData;
  int checks = 0;
  int errors = 0;
  int validCnt = 0;
  int errorCnt = 0;
  int doneCnt = 0;

  assign sda = mLow ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_target_buffered dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl      (scl),
    .sda      (sda),
    .rx_data  (rx_data),
    .rx_count (rx_count),
    .rx_valid (rx_valid),
    .rx_error (rx_error),
    .tx_data  (txData),
    .tx_done  (tx_done),
    .busy     (busy)
  );

  // Count high cycles of each pulse output, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) validCnt++;
    if (rx_error === 1'b1) errorCnt++;
    if (tx_done === 1'b1)  doneCnt++;
  end

  // Bus primitives; the master only changes sda while scl is low, except
  // for START/STOP.
  task automatic i2cStart();
    mLow = 1'b0; #Q; scl = 1'b1; #Q; mLow = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2cStop();
    mLow = 1'b1; #Q; scl = 1'b1; #Q; mLow = 1'b0; #Q;
  endtask

  task automatic sendBit(input logic b);
    mLow = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic recvBit(output logic b);
    mLow = 1'b0; #Q; scl = 1'b1; #Q; b = (sda === 1'b0) ? 1'b0 : 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic sendByte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) sendBit(d[i]);
    recvBit(b);
    ack = ~b;
  endtask

  task automatic recvByte(output logic [7:0] d, input logic ackIt);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recvBit(b);
      d[i] = b;
    end
    sendBit(~ackIt);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #(3*Q);
    checks++;
    if (sda !== 1'b1) begin errors++; $display("[TB] FAIL reset_sda: got %b expected 1", sda); end
    checks++;
    if (rx_count !== 10'd0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_count_busy: got %0d/%b expected 0/0", rx_count, busy);
    end
    checks++;
    if (rx_data !== 264'd0 || rx_valid !== 1'b0 || rx_error !== 1'b0 || tx_done !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_outputs: got data %0h pulses %b%b%b expected 0", rx_data, rx_valid, rx_error, tx_done);
    end
    reset_n = 1'b1;
    #(2*Q);
    expData = '0;
  endtask

  task automatic test_full_write(input logic [7:0] base);
    int v0, e0, nacks;
    logic ack;
    v0 = validCnt; e0 = errorCnt; nacks = 0;
    i2cStart();
    sendByte(8'hD4, ack);
    if (!ack) nacks++;
    for (int i = 0; i < 33; i++) begin
      sendByte(base + 8'(i), ack);
      if (!ack) nacks++;
      expData[8*(32-i) +: 8] = base + 8'(i);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL full_busy: got %b expected 1", busy); end
    i2cStop();
    #(3*Q);
    checks++;
    if (nacks != 0) begin errors++; $display("[TB] FAIL full_acks: got %0d NACKs expected 0", nacks); end
    checks++;
    if (rx_count !== 10'd33) begin errors++; $display("[TB] FAIL full_count: got %0d expected 33", rx_count); end
    checks++;
    if (validCnt - v0 != 1 || errorCnt != e0) begin
      errors++; $display("[TB] FAIL full_pulses: got valid %0d error %0d expected 1 0", validCnt - v0, errorCnt - e0);
    end
    checks++;
    if (rx_data !== expData) begin errors++; $display("[TB] FAIL full_data: got %0h expected %0h", rx_data, expData); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL full_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_addr_mismatch();
    int v0, e0, acks;
    logic ack;
    v0 = validCnt; e0 = errorCnt; acks = 0;
    i2cStart();
    sendByte(8'hAA, ack);
    if (ack) acks++;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mismatch_busy: got %b expected 0", busy); end
    sendByte(8'h11, ack);
    if (ack) acks++;
    sendByte(8'h22, ack);
    if (ack) acks++;
    i2cStop();
    #(3*Q);
    checks++;
    if (acks != 0) begin errors++; $display("[TB] FAIL mismatch_ack: got %0d ACKs expected 0", acks); end
    checks++;
    if (rx_count !== 10'd33 || rx_data !== expData) begin
      errors++; $display("[TB] FAIL mismatch_state: got count %0d data %0h expected 33 %0h", rx_count, rx_data, expData);
    end
    checks++;
    if (validCnt != v0 || errorCnt != e0) begin
      errors++; $display("[TB] FAIL mismatch_pulses: got valid %0d error %0d expected 0 0", validCnt - v0, errorCnt - e0);
    end
  endtask

  task automatic test_overflow();
    int v0, nackIdx, nacks;
    logic ack;
    v0 = validCnt; nackIdx = -1; nacks = 0;
    i2cStart();
    sendByte(8'hD4, ack);
    for (int i = 0; i < 34; i++) begin
      sendByte(8'h40 + 8'(i), ack);
      if (!ack) begin nacks++; nackIdx = i; end
      if (i < 33) expData[8*(32-i) +: 8] = 8'h40 + 8'(i);
    end
    i2cStop();
    #(3*Q);
    checks++;
    if (nacks != 1 || nackIdx != 33) begin
      errors++; $display("[TB] FAIL overflow_nack: got %0d NACKs last at %0d expected 1 at 33", nacks, nackIdx);
    end
    checks++;
    if (rx_count !== 10'd33 || rx_data[7:0] !== 8'h60) begin
      errors++; $display("[TB] FAIL overflow_count: got %0d last %0h expected 33 60", rx_count, rx_data[7:0]);
    end
    checks++;
    if (rx_data !== expData) begin errors++; $display("[TB] FAIL overflow_data: got %0h expected %0h", rx_data, expData); end
    checks++;
    if (validCnt - v0 != 1) begin errors++; $display("[TB] FAIL overflow_valid: got %0d expected 1", validCnt - v0); end
  endtask

  task automatic test_repeated_start();
    int v0, e0;
    logic ack;
    v0 = validCnt; e0 = errorCnt;
    i2cStart();
    sendByte(8'hD4, ack);
    for (int i = 0; i < 5; i++) begin
      sendByte(8'h80 + 8'(i), ack);
      expData[8*(32-i) +: 8] = 8'h80 + 8'(i);
    end
    i2cStart();
    i2cStop();
    #(3*Q);
    checks++;
    if (errorCnt - e0 != 1 || validCnt != v0) begin
      errors++; $display("[TB] FAIL rstart_pulses: got error %0d valid %0d expected 1 0", errorCnt - e0, validCnt - v0);
    end
    checks++;
    if (rx_count !== 10'd5) begin errors++; $display("[TB] FAIL rstart_count: got %0d expected 5", rx_count); end
    checks++;
    if (rx_data !== expData) begin errors++; $display("[TB] FAIL rstart_data: got %0h expected %0h", rx_data, expData); end
    test_full_write(8'hA0);
  endtask

  task automatic test_read();
    int d0, v0, bad;
    logic ack;
    logic [7:0] d;
    d0 = doneCnt; v0 = validCnt; bad = 0;
    i2cStart();
    sendByte(8'hD5, ack);
`ifdef I2C_TARGET_READ_EN
    checks++;
    if (ack !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL read_addr_ack: got ack %b busy %b expected 1 1", ack, busy);
    end
    for (int k = 0; k < 16; k++) begin
      recvByte(d, k < 15);
      if (d !== txData[8*(15-k) +: 8]) begin
        bad++; $display("[TB] FAIL read_byte%0d: got %0h expected %0h", k, d, txData[8*(15-k) +: 8]);
      end
    end
    #(2*Q);
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL read_bytes: got %0d wrong bytes expected 0", bad); end
    checks++;
    if (sda !== 1'b1) begin errors++; $display("[TB] FAIL read_release: got %b expected 1", sda); end
    i2cStop();
    #(3*Q);
    checks++;
    if (doneCnt - d0 != 1) begin errors++; $display("[TB] FAIL read_done: got %0d expected 1", doneCnt - d0); end
`else
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL read_disabled_ack: got ack %b busy %b expected 0 0", ack, busy);
    end
    recvByte(d, 1'b0);
    checks++;
    if (d !== 8'hFF) begin errors++; $display("[TB] FAIL read_disabled_bus: got %0h expected ff", d); end
    i2cStop();
    #(3*Q);
    checks++;
    if (doneCnt != d0) begin errors++; $display("[TB] FAIL read_disabled_done: got %0d expected 0", doneCnt - d0); end
`endif
    checks++;
    if (validCnt != v0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL read_end: got valid %0d busy %b expected 0 0", validCnt - v0, busy);
    end
  endtask

  task automatic test_reset_midtransfer();
    i2cStart();
    for (int i = 7; i >= 0; i--) sendBit(i == 0 ? 1'b0 : (8'hD4 >> i) & 8'h01 ? 1'b1 : 1'b0);
    mLow = 1'b0;
    #Q;
    checks++;
    if (sda !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset_ack_driven: got sda %b busy %b expected 0 1", sda, busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (sda !== 1'b1) begin errors++; $display("[TB] FAIL midreset_release: got %b expected 1", sda); end
    checks++;
    if (busy !== 1'b0 || rx_count !== 10'd0 || rx_data !== 264'd0) begin
      errors++; $display("[TB] FAIL midreset_outputs: got busy %b count %0d data %0h expected 0", busy, rx_count, rx_data);
    end
    scl = 1'b1;
    #Q;
    reset_n = 1'b1;
    #(2*Q);
    expData = '0;
    test_full_write(8'h00);
  endtask

  initial begin
    test_reset();
    test_full_write(8'h00);
    test_addr_mismatch();
    test_overflow();
    test_repeated_start();
    test_read();
    test_reset_midtransfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
